metronome_arm_sequencer: RTL

Drives the address port of the metronome-arm coordinate ROM (19-bit words, 7-bit address, one-cycle registered read). It sweeps the address back and forth at the user tempo, captures each returned word and unpacks it into arm-tip screen coordinates for the VGA renderer. It also emits a one-cycle beat pulse at each end of the swing for the click generator.

---
 rtl/metronome_arm_sequencer_if.sv | 27 ++
 rtl/metronome_arm_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/metronome_arm_sequencer_if.sv
// rtl/metronome_arm_sequencer_if.sv - tempo, ROM port and renderer signals of the metronome arm sequencer
// master = sequencer side, slave = ROM/tempo/renderer side.
interface metronome_arm_sequencer_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 19
);
    logic                  enable;
    logic [8:0]            bpm;
    logic                  frame_sync;
    logic [DATA_WIDTH-1:0] rom_q;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [9:0]            arm_x;
    logic [8:0]            arm_y;
    logic                  arm_valid;
    logic                  beat;
    logic                  dir;

    modport master (
        input  enable, bpm, frame_sync, rom_q,
        output rom_addr, arm_x, arm_y, arm_valid, beat, dir
    );

    modport slave (
        output enable, bpm, frame_sync, rom_q,
        input  rom_addr, arm_x, arm_y, arm_valid, beat, dir
    );
endinterface

// File: rtl/metronome_arm_sequencer.sv
// rtl/metronome_arm_sequencer.sv - ping-pong ROM address sweep at tempo, word fetch and arm coordinate unpack
// Optional METRONOME_FRAME_SYNC_EN: present new coordinates only on frame_sync after a completed load.
module metronome_arm_sequencer #(
    parameter int          ADDR_WIDTH        = 7,
    parameter int          DATA_WIDTH        = 19,
    parameter int          NUM_POS           = 128,
    parameter int          ACC_WIDTH         = 32,
    parameter int unsigned PHASE_INC_PER_BPM = 182
) (
    input logic                       i_clk,
    input logic                       i_reset,
    metronome_arm_sequencer_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_LOAD} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_POS - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_step;
    logic                  r_dir;
    logic                  w_dir_step;
    logic                  r_pending;
    logic                  r_beat;
    logic [9:0]            r_arm_x;
    logic [8:0]            r_arm_y;
    logic                  r_arm_valid;
    logic [8:0]            w_bpm_c;
    logic [ACC_WIDTH-1:0]  w_inc;
    logic [ACC_WIDTH:0]    w_sum;
    logic                  w_tick;
    logic                  w_step;

    // Truncating both factors first gives the same low ACC_WIDTH bits as the full product.
    always_comb begin
        w_bpm_c = (bus.bpm > 9'd300) ? 9'd300 : bus.bpm;
        w_inc   = ACC_WIDTH'(w_bpm_c) * ACC_WIDTH'(PHASE_INC_PER_BPM);
        w_sum   = {1'b0, r_acc} + {1'b0, w_inc};
        w_tick  = bus.enable & w_sum[ACC_WIDTH];
    end

    always_comb begin
        w_addr_step = r_addr + 1'b1;
        w_dir_step  = r_dir;
        if (!r_dir) begin
            if (r_addr == LAST_ADDR) begin
                w_dir_step  = 1'b1;
                w_addr_step = r_addr - 1'b1;
            end
        end else if (r_addr == '0) begin
            w_dir_step = 1'b0;
        end else begin
            w_addr_step = r_addr - 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_step       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick || r_pending) begin
                    w_step       = 1'b1;
                    w_state_next = S_ADDR;
                end
            end
            S_ADDR:  w_state_next = S_WAIT;
            S_WAIT:  w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Reset lands in ADDR so the address-0 word is fetched without a step.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_ADDR;
            r_acc     <= '0;
            r_addr    <= '0;
            r_dir     <= 1'b0;
            r_pending <= 1'b0;
            r_beat    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_beat  <= 1'b0;
            if (bus.enable) begin
                r_acc <= w_sum[ACC_WIDTH-1:0];
            end
            if (r_state == S_IDLE) begin
                r_pending <= 1'b0;
            end else if (w_tick) begin
                r_pending <= 1'b1;
            end
            if (w_step) begin
                r_addr <= w_addr_step;
                r_dir  <= w_dir_step;
                r_beat <= (w_addr_step == '0) || (w_addr_step == LAST_ADDR);
            end
        end
    end

`ifdef METRONOME_FRAME_SYNC_EN
    logic [9:0] r_pend_x;
    logic [8:0] r_pend_y;
    logic       r_new;

    // A frame_sync coinciding with LOAD defers the new word to the next frame_sync.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pend_x    <= '0;
            r_pend_y    <= '0;
            r_new       <= 1'b0;
            r_arm_x     <= '0;
            r_arm_y     <= '0;
            r_arm_valid <= 1'b0;
        end else begin
            r_arm_valid <= 1'b0;
            if (r_state == S_WAIT) begin
                r_pend_x <= bus.rom_q[DATA_WIDTH-1 -: 10];
                r_pend_y <= bus.rom_q[8:0];
            end
            if (r_state == S_LOAD) begin
                r_new <= 1'b1;
            end else if (bus.frame_sync && r_new) begin
                r_new       <= 1'b0;
                r_arm_x     <= r_pend_x;
                r_arm_y     <= r_pend_y;
                r_arm_valid <= 1'b1;
            end
        end
    end
`else
    logic w_unused_frame_sync;
    assign w_unused_frame_sync = bus.frame_sync;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_arm_x     <= '0;
            r_arm_y     <= '0;
            r_arm_valid <= 1'b0;
        end else begin
            r_arm_valid <= 1'b0;
            if (r_state == S_WAIT) begin
                r_arm_x     <= bus.rom_q[DATA_WIDTH-1 -: 10];
                r_arm_y     <= bus.rom_q[8:0];
                r_arm_valid <= 1'b1;
            end
        end
    end
`endif

    assign bus.rom_addr  = r_addr;
    assign bus.dir       = r_dir;
    assign bus.beat      = r_beat;
    assign bus.arm_x     = r_arm_x;
    assign bus.arm_y     = r_arm_y;
    assign bus.arm_valid = r_arm_valid;
endmodule
